l2_burst_adapter: RTL and testbench

L2_BURST_ADAPTER -- requirements
Module: l2_burst_adapter

---
 rtl/l2_pkg.sv | 17 +
 rtl/l2_burst_adapter.sv | 103 ++++++++++
 tb/tb_l2_burst_adapter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_pkg.sv
// Shared constants and FSM state encoding for the L2 line <-> memory burst adapter.
package l2_pkg;

    localparam int unsigned OFFSET_W  = 5;
    localparam int unsigned LINE_W    = 8 * (2 ** OFFSET_W);
    localparam int unsigned BEAT_W    = 64;
    localparam int unsigned BURST_LEN = LINE_W / BEAT_W;
    localparam int unsigned CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WB,
        ST_DONE
    } state_e;

endpackage

// File: rtl/l2_burst_adapter.sv
// Converts single-cycle L2 line fill/writeback requests into multi-beat memory bursts,
// assembling fill beats into a line and slicing the victim line into writeback beats.
module l2_burst_adapter
    import l2_pkg::*;
#(
    parameter int unsigned s_offset = OFFSET_W,
    parameter int unsigned s_line   = LINE_W,
    parameter int unsigned s_beat   = BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_addr,
    input  logic [s_line-1:0] line_wdata,
    output logic [s_line-1:0] line_rdata,
    output logic              line_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [s_beat-1:0] mem_wdata,
    input  logic [s_beat-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int unsigned burst_len = s_line / s_beat;
    localparam int unsigned cnt_w     = (burst_len > 1) ? $clog2(burst_len) : 1;
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(burst_len - 1);

    state_e            state;
    logic [cnt_w-1:0]  cnt;
    logic [cnt_w-1:0]  cnt_nxt_c;
    logic [s_line-1:0] wb_buf;
    logic [31:0]       aligned_addr_c;
    logic              unused_addr_bits;

    assign aligned_addr_c   = {line_addr[31:s_offset], {s_offset{1'b0}}};
    assign unused_addr_bits = ^line_addr[s_offset-1:0];
    assign cnt_nxt_c        = (cnt == last_beat) ? '0 : cnt + cnt_w'(1);

    // Burst FSM; mem_wdata is preloaded with the beat the memory will take next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            line_rdata <= '0;
            wb_buf     <= '0;
            line_resp  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            line_resp <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (line_read) begin
                        mem_addr <= aligned_addr_c;
                        cnt      <= '0;
                        mem_read <= 1'b1;
                        state    <= ST_FILL;
                    end else if (line_write) begin
                        mem_addr  <= aligned_addr_c;
                        cnt       <= '0;
                        wb_buf    <= line_wdata;
                        mem_wdata <= line_wdata[s_beat-1:0];
                        mem_write <= 1'b1;
                        state     <= ST_WB;
                    end
                end
                ST_FILL: begin
                    if (mem_resp) begin
                        line_rdata[s_beat*32'(cnt) +: s_beat] <= mem_rdata;
                        cnt <= cnt_nxt_c;
                        if (cnt == last_beat) begin
                            mem_read  <= 1'b0;
                            line_resp <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_WB: begin
                    if (mem_resp) begin
                        mem_wdata <= wb_buf[s_beat*32'(cnt_nxt_c) +: s_beat];
                        cnt       <= cnt_nxt_c;
                        if (cnt == last_beat) begin
                            mem_write <= 1'b0;
                            line_resp <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_burst_adapter.sv
// Scoreboard bench for l2_burst_adapter: expected lines/beats are queued when requests are issued.
module tb_l2_burst_adapter;

    localparam int unsigned S_OFFSET = 5;
    localparam int unsigned S_LINE   = 256;
    localparam int unsigned S_BEAT   = 64;
    localparam int unsigned NB       = S_LINE / S_BEAT;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              line_read;
    logic              line_write;
    logic [31:0]       line_addr;
    logic [S_LINE-1:0] line_wdata;
    logic [S_LINE-1:0] line_rdata;
    logic              line_resp;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [S_BEAT-1:0] mem_wdata;
    logic [S_BEAT-1:0] mem_rdata;
    logic              mem_resp;

    int total = 0;
    int bad   = 0;

    logic [S_LINE-1:0] q_line[$];
    logic [S_BEAT-1:0] q_beat[$];
    logic [S_LINE-1:0] last_line;

    l2_burst_adapter #(
        .s_offset(S_OFFSET),
        .s_line  (S_LINE),
        .s_beat  (S_BEAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_read (line_read),
        .line_write(line_write),
        .line_addr (line_addr),
        .line_wdata(line_wdata),
        .line_rdata(line_rdata),
        .line_resp (line_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [31:0] addr, input logic [S_LINE-1:0] line,
                           input int stall, input bit also_write, input string tag);
        logic [31:0]       exp_addr;
        logic [S_LINE-1:0] exp_line;
        exp_addr   = {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
        line_read  = 1'b1;
        line_write = also_write;
        line_addr  = addr;
        line_wdata = ~line;
        q_line.push_back(line);
        tick();
        line_read = 1'b0;
        line_addr = 32'hFFFF_FFFF;
        for (int k = 0; k < NB; k++) begin
            for (int s = 0; s <= stall; s++) begin
                total++;
                if (mem_read !== 1'b1 || mem_write !== 1'b0 || line_resp !== 1'b0 || mem_addr !== exp_addr) begin
                    bad++;
                    $display("FAIL %s fill_hold beat%0d: rd=%b wr=%b resp=%b addr=%h, want rd=1 wr=0 resp=0 addr=%h",
                             tag, k, mem_read, mem_write, line_resp, mem_addr, exp_addr);
                end
                mem_resp  = (s == stall);
                mem_rdata = (s == stall) ? line[k*S_BEAT +: S_BEAT] : S_BEAT'({$urandom, $urandom});
                tick();
            end
        end
        mem_resp   = 1'b0;
        line_write = 1'b0;
        total++;
        if (line_resp !== 1'b1 || mem_read !== 1'b0) begin
            bad++;
            $display("FAIL %s fill_done: resp=%b rd=%b, want resp=1 rd=0", tag, line_resp, mem_read);
        end
        exp_line = q_line.pop_front();
        total++;
        if (line_rdata !== exp_line) begin
            bad++;
            $display("FAIL %s fill_data: got %h want %h", tag, line_rdata, exp_line);
        end
        last_line = exp_line;
        tick();
        total++;
        if (line_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL %s fill_idle: resp=%b rd=%b wr=%b, want all 0", tag, line_resp, mem_read, mem_write);
        end
    endtask

    task automatic do_wb(input logic [31:0] addr, input logic [S_LINE-1:0] line,
                         input int stall, input string tag);
        logic [31:0] exp_addr;
        exp_addr   = {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
        line_write = 1'b1;
        line_addr  = addr;
        line_wdata = line;
        for (int k = 0; k < NB; k++) q_beat.push_back(line[k*S_BEAT +: S_BEAT]);
        tick();
        line_write = 1'b0;
        line_wdata = '0;
        line_addr  = 32'h0;
        for (int k = 0; k < NB; k++) begin
            for (int s = 0; s <= stall; s++) begin
                total++;
                if (mem_write !== 1'b1 || mem_read !== 1'b0 || line_resp !== 1'b0 ||
                    mem_addr !== exp_addr || mem_wdata !== q_beat[0]) begin
                    bad++;
                    $display("FAIL %s wb_beat%0d: wr=%b rd=%b resp=%b addr=%h wdata=%h, want wr=1 rd=0 resp=0 addr=%h wdata=%h",
                             tag, k, mem_write, mem_read, line_resp, mem_addr, mem_wdata, exp_addr, q_beat[0]);
                end
                mem_resp = (s == stall);
                tick();
            end
            void'(q_beat.pop_front());
        end
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL %s wb_done: resp=%b wr=%b, want resp=1 wr=0", tag, line_resp, mem_write);
        end
        tick();
        total++;
        if (line_resp !== 1'b0 || mem_write !== 1'b0 || line_rdata !== last_line) begin
            bad++;
            $display("FAIL %s wb_idle: resp=%b wr=%b rdata=%h, want resp=0 wr=0 rdata=%h",
                     tag, line_resp, mem_write, line_rdata, last_line);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if (line_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== '0 || line_rdata !== '0) begin
            bad++;
            $display("FAIL reset_state: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, want all 0",
                     line_resp, mem_read, mem_write, mem_addr, mem_wdata, line_rdata);
        end
        rst_n = 1'b1;
        last_line = '0;
        tick();
    endtask

    task automatic test_fill();
        do_fill(32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 1'b0, "fill_basic");
    endtask

    task automatic test_writeback();
        do_wb(32'h0000_5678, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 0, "wb_basic");
        do_wb(32'hCAFE_00FF, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              2, "wb_stall");
    endtask

    task automatic test_fill_stall();
        do_fill(32'h8000_0040, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                3, 1'b0, "fill_stall");
    endtask

    task automatic test_read_write_priority();
        do_fill(32'h0000_ABCD, {{16{4'h9}}, {16{4'h8}}, {16{4'h7}}, {16{4'h6}}}, 0, 1'b1, "rw_both");
    endtask

    task automatic test_reset_mid_burst();
        line_read = 1'b1;
        line_addr = 32'h1234_5678;
        tick();
        line_read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = {2{32'h5A5A_0000 + 32'(k)}};
            tick();
        end
        mem_resp = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_read !== 1'b0 || line_rdata !== '0 || mem_addr !== 32'h0 || line_resp !== 1'b0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL rst_mid: rd=%b rdata=%h addr=%h resp=%b wdata=%h, want all 0",
                     mem_read, line_rdata, mem_addr, line_resp, mem_wdata);
        end
        tick();
        rst_n = 1'b1;
        last_line = '0;
        tick();
        do_fill(32'h0000_0400, {{16{4'hE}}, {16{4'h7}}, {16{4'h5}}, {16{4'h3}}}, 0, 1'b0, "post_rst");
    endtask

    task automatic test_idle_resp();
        for (int i = 0; i < 3; i++) begin
            mem_resp  = 1'b1;
            mem_rdata = {$urandom, $urandom};
            tick();
            total++;
            if (line_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || line_rdata !== last_line) begin
                bad++;
                $display("FAIL idle_resp%0d: resp=%b rd=%b wr=%b rdata=%h, want resp=0 rd=0 wr=0 rdata=%h",
                         i, line_resp, mem_read, mem_write, line_rdata, last_line);
            end
        end
        mem_resp = 1'b0;
        tick();
        do_fill(32'h0000_0020, {{16{4'hF}}, {16{4'h0}}, {16{4'hF}}, {16{4'h0}}}, 0, 1'b0, "after_idle");
    endtask

    task automatic test_back_to_back();
        do_wb(32'h0000_1000, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              0, "b2b_wb");
        do_fill(32'h0000_2000, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                1, 1'b0, "b2b_fill");
    endtask

    initial begin
        line_read  = 1'b0;
        line_write = 1'b0;
        line_addr  = '0;
        line_wdata = '0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;
        last_line  = '0;
        test_reset();
        test_fill();
        test_writeback();
        test_fill_stall();
        test_read_write_priority();
        test_reset_mid_burst();
        test_idle_resp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
